// File: rtl/pll_phase_ctrl.sv
// Dynamic phase-shift controller for a PLL with PHASESEL/PHASEDIR/PHASESTEP controls.
// Sequences a requested number of phase steps on one PLL output, tracks the accumulated
// position of every output, and holds the downstream domain in reset until lock is stable.
module pll_phase_ctrl #(
  parameter int unsigned SETUP_CYC   = 2,
  parameter int unsigned STEP_CYC    = 4,
  parameter int unsigned GAP_CYC     = 4,
  parameter int unsigned SETTLE_CYC  = 16,
  parameter int unsigned LOCK_STABLE = 1024
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       pll_locked,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_sel,
  input  logic       req_dir,
  input  logic [7:0] req_steps,
  output logic [1:0] phasesel,
  output logic       phasedir,
  output logic       phasestep,
  output logic       phaseloadreg,
  output logic       done,
  output logic       err,
  input  logic [1:0] pos_sel,
  output logic [7:0] pos_val,
  output logic       rst_out_n
);

  localparam logic [2:0] StWaitLock = 3'd0;
  localparam logic [2:0] StIdle     = 3'd1;
  localparam logic [2:0] StSetup    = 3'd2;
  localparam logic [2:0] StStep     = 3'd3;
  localparam logic [2:0] StGap      = 3'd4;
  localparam logic [2:0] StSettle   = 3'd5;

  // Phase-length counter; 16 bits covers any sensible cycle parameter.
  localparam int unsigned CntW = 16;
  localparam logic [CntW-1:0] SetupLast  = CntW'(SETUP_CYC - 1);
  localparam logic [CntW-1:0] StepLast   = CntW'(STEP_CYC - 1);
  localparam logic [CntW-1:0] GapLast    = CntW'(GAP_CYC - 1);
  localparam logic [CntW-1:0] SettleLast = CntW'(SETTLE_CYC - 1);

  localparam int unsigned StW = (LOCK_STABLE > 2) ? $clog2(LOCK_STABLE) : 1;
  localparam logic [StW-1:0] StableLast = StW'(LOCK_STABLE - 1);

  logic            lock_meta_q, lock_sync_q;
  logic            locked;

  logic [2:0]      state_q, state_d;
  logic [StW-1:0]  stable_q, stable_d;
  logic [CntW-1:0] cyc_q, cyc_d;
  logic [7:0]      left_q, left_d;
  logic [1:0]      sel_q, sel_d;
  logic            dir_q, dir_d;
  // A completed sequence reports done one cycle after the return to idle.
  logic            pend_q, pend_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic            ready_q, ready_d;
  logic            step_q, step_d;
  logic            rst_out_q, rst_out_d;
  logic [7:0]      pos_q [4];
  logic [7:0]      pos_d [4];
  logic            step_done;

  assign locked = lock_sync_q;

  // Two-flop synchronizer for the asynchronous PLL lock indication.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      lock_meta_q <= 1'b0;
      lock_sync_q <= 1'b0;
    end else begin
      lock_meta_q <= pll_locked;
      lock_sync_q <= lock_meta_q;
    end
  end

  // Next-state logic for the lock-wait and phase-step sequencer.
  always_comb begin
    state_d   = state_q;
    stable_d  = stable_q;
    cyc_d     = cyc_q;
    left_d    = left_q;
    sel_d     = sel_q;
    dir_d     = dir_q;
    pend_d    = 1'b0;
    done_d    = 1'b0;
    err_d     = 1'b0;
    rst_out_d = rst_out_q;
    step_done = 1'b0;

    if (state_q == StWaitLock) begin
      rst_out_d = 1'b0;
      if (!locked) begin
        stable_d = '0;
      end else if (stable_q == StableLast) begin
        state_d   = StIdle;
        stable_d  = '0;
        rst_out_d = 1'b1;
      end else begin
        stable_d = stable_q + 1'b1;
      end
    end else if (!locked) begin
      // Lock loss beats everything, including a request in the same idle cycle.
      state_d   = StWaitLock;
      stable_d  = '0;
      cyc_d     = '0;
      rst_out_d = 1'b0;
      if (state_q != StIdle) begin
        done_d = 1'b1;
        err_d  = 1'b1;
      end
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_valid && ready_q) begin
            sel_d  = req_sel;
            dir_d  = req_dir;
            left_d = req_steps;
            cyc_d  = '0;
            if (req_steps == 8'd0) begin
              pend_d = 1'b1;
            end else begin
              state_d = StSetup;
            end
          end
        end
        StSetup: begin
          if (cyc_q == SetupLast) begin
            state_d = StStep;
            cyc_d   = '0;
          end else begin
            cyc_d = cyc_q + 1'b1;
          end
        end
        StStep: begin
          if (cyc_q == StepLast) begin
            // Step counts on the rising edge of phasestep.
            state_d   = StGap;
            cyc_d     = '0;
            left_d    = left_q - 8'd1;
            step_done = 1'b1;
          end else begin
            cyc_d = cyc_q + 1'b1;
          end
        end
        StGap: begin
          if (cyc_q == GapLast) begin
            cyc_d   = '0;
            state_d = (left_q == 8'd0) ? StSettle : StStep;
          end else begin
            cyc_d = cyc_q + 1'b1;
          end
        end
        StSettle: begin
          if (cyc_q == SettleLast) begin
            state_d = StIdle;
            cyc_d   = '0;
            pend_d  = 1'b1;
          end else begin
            cyc_d = cyc_q + 1'b1;
          end
        end
        default: begin
          state_d = StWaitLock;
          cyc_d   = '0;
        end
      endcase
    end

    if (pend_q) begin
      done_d = 1'b1;
    end
  end

  // Registered outputs are derived from the next state so they switch glitch-free.
  always_comb begin
    ready_d = (state_d == StIdle) && !pend_d;
    step_d  = (state_d != StStep);
  end

  // Per-output position accumulators, modulo 256.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      pos_d[i] = pos_q[i];
    end
    if (step_done) begin
      pos_d[sel_q] = dir_q ? (pos_q[sel_q] + 8'd1) : (pos_q[sel_q] - 8'd1);
    end
  end

  // Sequencer state and counters.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StWaitLock;
      stable_q <= '0;
      cyc_q    <= '0;
      left_q   <= '0;
      pend_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      stable_q <= stable_d;
      cyc_q    <= cyc_d;
      left_q   <= left_d;
      pend_q   <= pend_d;
    end
  end

  // Latched request fields and position registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sel_q <= 2'b00;
      dir_q <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        pos_q[i] <= '0;
      end
    end else begin
      sel_q <= sel_d;
      dir_q <= dir_d;
      for (int i = 0; i < 4; i++) begin
        pos_q[i] <= pos_d[i];
      end
    end
  end

  // Output registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      ready_q   <= 1'b0;
      step_q    <= 1'b1;
      rst_out_q <= 1'b0;
    end else begin
      done_q    <= done_d;
      err_q     <= err_d;
      ready_q   <= ready_d;
      step_q    <= step_d;
      rst_out_q <= rst_out_d;
    end
  end

  assign req_ready    = ready_q;
  assign phasesel     = sel_q;
  assign phasedir     = dir_q;
  assign phasestep    = step_q;
  assign phaseloadreg = 1'b1;
  assign done         = done_q;
  assign err          = err_q;
  assign rst_out_n    = rst_out_q;
  assign pos_val      = pos_q[pos_sel];

endmodule

// File: tb/tb_pll_phase_ctrl.sv
// Scoreboard bench for pll_phase_ctrl: expectations are queued at request time and
// checked when the done pulse arrives.
module tb_pll_phase_ctrl;

  localparam int unsigned SetupCyc   = 2;
  localparam int unsigned StepCyc    = 4;
  localparam int unsigned GapCyc     = 4;
  localparam int unsigned SettleCyc  = 16;
  localparam int unsigned LockStable = 1024;
  localparam int unsigned StartLat   = 2 + LockStable;

  logic       clock      = 1'b0;
  logic       reset_n    = 1'b0;
  logic       pll_locked = 1'b0;
  logic       req_valid  = 1'b0;
  logic [1:0] req_sel    = 2'b00;
  logic       req_dir    = 1'b0;
  logic [7:0] req_steps  = 8'd0;
  logic [1:0] pos_sel    = 2'b00;
  logic       req_ready;
  logic [1:0] phasesel;
  logic       phasedir, phasestep, phaseloadreg, done, err, rst_out_n;
  logic [7:0] pos_val;

  pll_phase_ctrl #(
    .SETUP_CYC  (SetupCyc),
    .STEP_CYC   (StepCyc),
    .GAP_CYC    (GapCyc),
    .SETTLE_CYC (SettleCyc),
    .LOCK_STABLE(LockStable)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .pll_locked  (pll_locked),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_sel     (req_sel),
    .req_dir     (req_dir),
    .req_steps   (req_steps),
    .phasesel    (phasesel),
    .phasedir    (phasedir),
    .phasestep   (phasestep),
    .phaseloadreg(phaseloadreg),
    .done        (done),
    .err         (err),
    .pos_sel     (pos_sel),
    .pos_val     (pos_val),
    .rst_out_n   (rst_out_n)
  );

  always #5 clock = ~clock;

  int unsigned edge_cnt = 0;
  always @(posedge clock) edge_cnt <= edge_cnt + 32'd1;

  typedef struct {
    int unsigned done_edge;
    logic        err;
    logic [1:0]  sel;
    logic [7:0]  pos;
    int unsigned pulses;
    int unsigned low_cyc;
  } exp_t;

  exp_t        sb[$];
  logic [7:0]  model_pos [4];
  int unsigned checks = 0;
  int unsigned passes = 0;

  function automatic exp_t model_req(input int unsigned e0, input logic [1:0] sel,
                                     input logic dir, input int unsigned steps);
    exp_t e;
    e.done_edge = e0 + ((steps == 0) ? 1 :
                        SetupCyc + steps * (StepCyc + GapCyc) + SettleCyc + 1);
    e.err     = 1'b0;
    e.sel     = sel;
    e.pos     = dir ? model_pos[sel] + 8'(steps) : model_pos[sel] - 8'(steps);
    e.pulses  = steps;
    e.low_cyc = steps * StepCyc;
    return e;
  endfunction

  task automatic issue(input logic [1:0] sel, input logic dir, input logic [7:0] steps,
                       output logic was_ready, output int unsigned e0);
    @(negedge clock);
    was_ready = req_ready;
    req_sel   = sel;
    req_dir   = dir;
    req_steps = steps;
    req_valid = 1'b1;
    @(negedge clock);
    e0        = edge_cnt;
    req_valid = 1'b0;
  endtask

  // Follows phasestep until done or the budget runs out; optionally drops lock at drop_at.
  task automatic wait_done(input int unsigned budget, input int unsigned drop_at,
                           output logic seen, output int unsigned d_edge, output logic d_err,
                           output int unsigned pulses, output int unsigned low_cyc,
                           output int unsigned first_low);
    logic prev;
    seen = 1'b0; d_edge = 0; d_err = 1'b0; pulses = 0; low_cyc = 0; first_low = 0;
    prev = phasestep;
    for (int i = 0; i < int'(budget) && !seen; i++) begin
      @(negedge clock);
      if (drop_at != 0 && edge_cnt == drop_at) pll_locked = 1'b0;
      if (!phasestep) begin
        low_cyc++;
        if (prev) begin
          pulses++;
          if (pulses == 1) first_low = edge_cnt;
        end
      end
      prev = phasestep;
      if (done) begin
        seen   = 1'b1;
        d_edge = edge_cnt;
        d_err  = err;
      end
    end
  endtask

  task automatic read_pos(input logic [1:0] sel, output logic [7:0] v);
    pos_sel = sel;
    #1;
    v = pos_val;
  endtask

  task automatic test_reset();
    logic [7:0] v;
    reset_n    = 1'b0;
    pll_locked = 1'b1;
    repeat (3) @(negedge clock);
    checks++;
    if ({rst_out_n, req_ready, done, err, phasestep, phaseloadreg, phasesel, phasedir} !==
        9'b0000_1100_0)
      $display("FAIL reset_outputs: got %b want %b",
               {rst_out_n, req_ready, done, err, phasestep, phaseloadreg, phasesel, phasedir},
               9'b0000_1100_0);
    else passes++;
    for (int s = 0; s < 4; s++) begin
      read_pos(2'(s), v);
      checks++;
      if (v !== 8'd0) $display("FAIL reset_pos%0d: got %0d want 0", s, v);
      else passes++;
    end
  endtask

  task automatic test_startup();
    int unsigned base, rise;
    logic seen;
    @(negedge clock);
    reset_n = 1'b1;
    base = edge_cnt;
    seen = 1'b0; rise = 0;
    for (int i = 0; i < int'(StartLat) + 50 && !seen; i++) begin
      @(negedge clock);
      if (rst_out_n) begin
        seen = 1'b1;
        rise = edge_cnt;
      end
    end
    checks++;
    if (!seen || rise - base != StartLat)
      $display("FAIL startup_latency: got %0d (seen=%b) want %0d", rise - base, seen, StartLat);
    else passes++;
    checks++;
    if (req_ready !== 1'b1) $display("FAIL startup_ready: got %b want 1", req_ready);
    else passes++;
  endtask

  task automatic test_single_step();
    logic rdy, seen, d_err;
    int unsigned e0, d_edge, pulses, low_cyc, first_low;
    logic [7:0] v;
    exp_t e;
    issue(2'b01, 1'b1, 8'd1, rdy, e0);
    sb.push_back(model_req(e0, 2'b01, 1'b1, 1));
    model_pos[1] = sb[$].pos;
    wait_done(100, 0, seen, d_edge, d_err, pulses, low_cyc, first_low);
    e = sb.pop_front();
    checks++;
    if (rdy !== 1'b1) $display("FAIL single_ready: got %b want 1", rdy); else passes++;
    checks++;
    if (!seen || d_edge != e.done_edge)
      $display("FAIL single_done: got edge %0d want %0d", d_edge - e0, e.done_edge - e0);
    else passes++;
    checks++;
    if (d_err !== e.err) $display("FAIL single_err: got %b want %b", d_err, e.err); else passes++;
    checks++;
    if (pulses != e.pulses || low_cyc != e.low_cyc)
      $display("FAIL single_pulse: got %0d pulses/%0d low want %0d/%0d",
               pulses, low_cyc, e.pulses, e.low_cyc);
    else passes++;
    checks++;
    if (first_low != e0 + SetupCyc)
      $display("FAIL single_step_start: got %0d want %0d", first_low - e0, SetupCyc);
    else passes++;
    checks++;
    if ({phasesel, phasedir} !== 3'b011)
      $display("FAIL single_sel_dir: got %b want 011", {phasesel, phasedir});
    else passes++;
    read_pos(e.sel, v);
    checks++;
    if (v !== e.pos) $display("FAIL single_pos: got %0d want %0d", v, e.pos); else passes++;
  endtask

  task automatic test_wrap();
    logic rdy, seen, d_err;
    int unsigned e0, d_edge, pulses, low_cyc, first_low;
    logic [7:0] v;
    exp_t e;
    issue(2'b00, 1'b0, 8'd3, rdy, e0);
    sb.push_back(model_req(e0, 2'b00, 1'b0, 3));
    model_pos[0] = sb[$].pos;
    wait_done(200, 0, seen, d_edge, d_err, pulses, low_cyc, first_low);
    e = sb.pop_front();
    checks++;
    if (!seen || d_edge != e.done_edge || d_err !== e.err)
      $display("FAIL wrap_done: got edge %0d err %b want %0d err %b",
               d_edge - e0, d_err, e.done_edge - e0, e.err);
    else passes++;
    checks++;
    if (pulses != e.pulses || low_cyc != e.low_cyc)
      $display("FAIL wrap_pulse: got %0d pulses/%0d low want %0d/%0d",
               pulses, low_cyc, e.pulses, e.low_cyc);
    else passes++;
    read_pos(e.sel, v);
    checks++;
    if (v !== e.pos) $display("FAIL wrap_pos: got %0d want %0d", v, e.pos); else passes++;
  endtask

  task automatic test_zero();
    logic rdy, seen, d_err;
    int unsigned e0, d_edge, pulses, low_cyc, first_low;
    logic [7:0] v;
    exp_t e;
    issue(2'b00, 1'b1, 8'd0, rdy, e0);
    sb.push_back(model_req(e0, 2'b00, 1'b1, 0));
    wait_done(20, 0, seen, d_edge, d_err, pulses, low_cyc, first_low);
    e = sb.pop_front();
    checks++;
    if (!seen || d_edge != e.done_edge || d_err !== e.err)
      $display("FAIL zero_done: got edge %0d err %b want %0d err %b",
               d_edge - e0, d_err, e.done_edge - e0, e.err);
    else passes++;
    checks++;
    if (low_cyc != 0) $display("FAIL zero_phasestep: got %0d low cycles want 0", low_cyc);
    else passes++;
    read_pos(e.sel, v);
    checks++;
    if (v !== e.pos) $display("FAIL zero_pos: got %0d want %0d", v, e.pos); else passes++;
  endtask

  task automatic test_busy();
    logic rdy, seen, d_err;
    int unsigned e0, d_edge, early, extra;
    logic [7:0] v;
    exp_t e;
    issue(2'b10, 1'b1, 8'd2, rdy, e0);
    sb.push_back(model_req(e0, 2'b10, 1'b1, 2));
    model_pos[2] = sb[$].pos;
    // Hold a second request throughout the sequence.
    req_sel = 2'b01; req_dir = 1'b0; req_steps = 8'd7; req_valid = 1'b1;
    seen = 1'b0; d_edge = 0; d_err = 1'b0; early = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clock);
      if (done) begin
        seen = 1'b1; d_edge = edge_cnt; d_err = err; req_valid = 1'b0;
      end else if (req_ready) begin
        early++;
      end
    end
    req_valid = 1'b0;
    e = sb.pop_front();
    checks++;
    if (early != 0) $display("FAIL busy_ready: got %0d ready cycles want 0", early);
    else passes++;
    checks++;
    if (!seen || d_edge != e.done_edge || d_err !== e.err)
      $display("FAIL busy_done: got edge %0d err %b want %0d err %b",
               d_edge - e0, d_err, e.done_edge - e0, e.err);
    else passes++;
    extra = 0;
    repeat (60) begin
      @(negedge clock);
      if (done) extra++;
    end
    checks++;
    if (extra != 0 || phasesel !== 2'b10)
      $display("FAIL busy_no_second: got %0d extra done sel %b want 0 sel 10", extra, phasesel);
    else passes++;
    read_pos(e.sel, v);
    checks++;
    if (v !== e.pos) $display("FAIL busy_pos: got %0d want %0d", v, e.pos); else passes++;
  endtask

  task automatic test_abort();
    logic rdy, seen, d_err;
    int unsigned e0, d_edge, pulses, low_cyc, first_low, drop, base, rise;
    logic [7:0] v;
    exp_t e;
    issue(2'b11, 1'b1, 8'd5, rdy, e0);
    // Lock drops right after the third STEP begins; two sync flops plus one edge to act.
    drop = e0 + SetupCyc + 2 * (StepCyc + GapCyc);
    e.done_edge = drop + 3;
    e.err       = 1'b1;
    e.sel       = 2'b11;
    e.pos       = model_pos[3] + 8'd2;
    e.pulses    = 3;
    e.low_cyc   = 2 * StepCyc + 3;
    sb.push_back(e);
    model_pos[3] = e.pos;
    wait_done(200, drop, seen, d_edge, d_err, pulses, low_cyc, first_low);
    e = sb.pop_front();
    checks++;
    if (!seen || d_edge != e.done_edge || d_err !== e.err)
      $display("FAIL abort_done: got edge %0d err %b want %0d err %b",
               d_edge - e0, d_err, e.done_edge - e0, e.err);
    else passes++;
    checks++;
    if ({rst_out_n, req_ready, phasestep} !== 3'b001)
      $display("FAIL abort_outputs: got %b want 001", {rst_out_n, req_ready, phasestep});
    else passes++;
    checks++;
    if (pulses != e.pulses || low_cyc != e.low_cyc)
      $display("FAIL abort_pulse: got %0d pulses/%0d low want %0d/%0d",
               pulses, low_cyc, e.pulses, e.low_cyc);
    else passes++;
    read_pos(e.sel, v);
    checks++;
    if (v !== e.pos) $display("FAIL abort_pos: got %0d want %0d", v, e.pos); else passes++;
    repeat (5) @(negedge clock);
    pll_locked = 1'b1;
    base = edge_cnt;
    seen = 1'b0; rise = 0;
    for (int i = 0; i < int'(StartLat) + 50 && !seen; i++) begin
      @(negedge clock);
      if (rst_out_n) begin
        seen = 1'b1;
        rise = edge_cnt;
      end
    end
    checks++;
    if (!seen || rise - base != StartLat || req_ready !== 1'b1)
      $display("FAIL relock: got %0d ready %b want %0d ready 1", rise - base, req_ready,
               StartLat);
    else passes++;
    read_pos(2'b11, v);
    checks++;
    if (v !== model_pos[3]) $display("FAIL relock_pos: got %0d want %0d", v, model_pos[3]);
    else passes++;
  endtask

  task automatic test_reset_mid();
    logic rdy;
    int unsigned e0, dones;
    logic [7:0] v;
    issue(2'b01, 1'b0, 8'd3, rdy, e0);
    repeat (12) @(negedge clock);
    reset_n = 1'b0;
    #1;
    checks++;
    if ({done, phasestep, rst_out_n, req_ready} !== 4'b0100)
      $display("FAIL midreset_outputs: got %b want 0100",
               {done, phasestep, rst_out_n, req_ready});
    else passes++;
    for (int s = 0; s < 4; s++) model_pos[s] = 8'd0;
    for (int s = 0; s < 4; s++) begin
      read_pos(2'(s), v);
      checks++;
      if (v !== model_pos[s]) $display("FAIL midreset_pos%0d: got %0d want 0", s, v);
      else passes++;
    end
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    dones = 0;
    repeat (60) begin
      @(negedge clock);
      if (done) dones++;
    end
    checks++;
    if (dones != 0) $display("FAIL midreset_no_done: got %0d want 0", dones); else passes++;
    checks++;
    if (sb.size() != 0) $display("FAIL scoreboard_empty: got %0d want 0", sb.size());
    else passes++;
  endtask

  initial begin
    for (int s = 0; s < 4; s++) model_pos[s] = 8'd0;
    test_reset();
    test_startup();
    test_single_step();
    test_wrap();
    test_zero();
    test_busy();
    test_abort();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed",
             passes, checks);
    $fatal(1, "watchdog");
  end

endmodule
